// File: rtl/pc_ctlr.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctlr
// Purpose  : Program counter / fetch sequencer with misaligned-target trap.
// Revision : 1.0  initial release
// ============================================================================
module pc_ctlr #(
  parameter int                    XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]       TRAP_VECTOR  = 32'h0000_0010,
  parameter int                    CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_src,
  input  logic             jalr_sel,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic             stall,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             commit,
  output logic             misalign_trap,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_trap_pc;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [XLEN-1:0]  w_jalr_sum;
  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic             w_exec_go;
  logic             w_taken;

  // JALR has priority over pc_src when the decoder asserts both.
  always_comb begin
    w_jalr_sum = rs1_data + imm;
    if (jalr_sel)
      w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    else if (pc_src)
      w_target = r_pc + imm;
    else
      w_target = r_pc + XLEN'(4);
  end

  assign w_misaligned = |w_target[1:0];
  assign w_exec_go    = (r_state == S_EXEC) && !stall;
  assign w_taken      = pc_src | jalr_sel;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_FETCH;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (imem_ack && !stall) w_next_state = S_EXEC;
      S_EXEC:  if (!stall) w_next_state = w_misaligned ? S_TRAP : S_FETCH;
      S_TRAP:  w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req      = (r_state == S_FETCH);
    commit        = w_exec_go && !w_misaligned;
    misalign_trap = (r_state == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_VECTOR;
      r_trap_pc   <= '0;
      r_taken_cnt <= '0;
    end else if (w_exec_go) begin
      if (w_misaligned) begin
        r_trap_pc <= r_pc;
        r_pc      <= TRAP_VECTOR;
      end else begin
        r_pc <= w_target;
        if (w_taken && (r_taken_cnt != {CNT_W{1'b1}}))
          r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  assign pc        = r_pc;
  assign pc_plus4  = r_pc + XLEN'(4);
  assign trap_pc   = r_trap_pc;
  assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctlr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ctlr
// Purpose  : Directed self-checking bench for pc_ctlr against a cycle model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_ctlr;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0010;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pc_src = 1'b0;
  logic             jalr_sel = 1'b0;
  logic [XLEN-1:0]  imm = '0;
  logic [XLEN-1:0]  rs1_data = '0;
  logic             stall = 1'b0;
  logic             imem_ack = 1'b0;
  logic             imem_req;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             commit;
  logic             misalign_trap;
  logic [XLEN-1:0]  trap_pc;
  logic [CNT_W-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_ctlr #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .jalr_sel(jalr_sel), .imm(imm),
    .rs1_data(rs1_data), .stall(stall), .imem_ack(imem_ack),
    .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4), .commit(commit),
    .misalign_trap(misalign_trap), .trap_pc(trap_pc), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Model: which step of the instruction lifecycle we are in, plus arch state.
  localparam int WAIT_FETCH = 0, EXECUTING = 1, TRAPPING = 2;
  int          m_phase = WAIT_FETCH;
  logic [31:0] m_pc = '0;
  logic [31:0] m_trap_pc = '0;
  int          m_cnt = 0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] model_target(input logic [31:0] cur_pc);
    logic [31:0] s;
    if (jalr_sel) begin
      s = rs1_data + imm;
      return s - (s % 2);
    end
    if (pc_src) return cur_pc + imm;
    return cur_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RV; m_phase = WAIT_FETCH; m_trap_pc = '0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        WAIT_FETCH: if (imem_ack && !stall) m_phase = EXECUTING;
        EXECUTING: if (!stall) begin
          tgt = model_target(m_pc);
          if (tgt % 4 != 0) begin
            m_trap_pc = m_pc; m_pc = TV; m_phase = TRAPPING;
          end else begin
            if ((pc_src || jalr_sel) && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_pc = tgt; m_phase = WAIT_FETCH;
          end
        end
        default: m_phase = WAIT_FETCH;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] tgt;
    if (m_valid && !rst) begin
      tgt = model_target(m_pc);
      cmp("imem_req", {31'd0, imem_req}, {31'd0, m_phase == WAIT_FETCH});
      cmp("pc", pc, m_pc);
      cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
      cmp("commit", {31'd0, commit},
          {31'd0, (m_phase == EXECUTING) && !stall && (tgt % 4 == 0)});
      cmp("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_phase == TRAPPING});
      cmp("trap_pc", trap_pc, m_trap_pc);
      cmp("taken_cnt", {30'd0, taken_cnt}, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic ps, input logic js, input logic [31:0] im,
                       input logic [31:0] r1);
    imem_ack = 1'b1; stall = 1'b0;
    step();
    imem_ack = 1'b0;
    pc_src = ps; jalr_sel = js; imm = im; rs1_data = r1;
    step();
    pc_src = 1'b0; jalr_sel = 1'b0;
  endtask

  initial begin
    step();
    rst = 1'b0;
    cmp("lit_reset_pc", pc, 32'h0);
    cmp("lit_reset_req", {31'd0, imem_req}, 32'd1);
    cmp("lit_reset_cnt", {30'd0, taken_cnt}, 32'd0);

    instr(1'b0, 1'b0, 32'h0, 32'h0);
    instr(1'b0, 1'b0, 32'h0, 32'h0);
    cmp("lit_seq_pc", pc, 32'h8);
    instr(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    cmp("lit_branch_pc", pc, 32'h0);
    cmp("lit_branch_cnt", {30'd0, taken_cnt}, 32'd1);
    instr(1'b0, 1'b0, 32'h40, 32'h0);
    cmp("lit_notaken_pc", pc, 32'h4);
    instr(1'b1, 1'b1, 32'h3, 32'h101);
    cmp("lit_jalr_pc", pc, 32'h104);
    cmp("lit_jalr_cnt", {30'd0, taken_cnt}, 32'd2);

    // Reset while stalled in EXEC with ack held high.
    imem_ack = 1'b1; step();
    stall = 1'b1; pc_src = 1'b1; imm = 32'h8; step();
    rst = 1'b1; step();
    rst = 1'b0; stall = 1'b0; pc_src = 1'b0; imem_ack = 1'b0;
    cmp("lit_rst_exec_pc", pc, 32'h0);
    cmp("lit_rst_exec_cnt", {30'd0, taken_cnt}, 32'd0);

    instr(1'b1, 1'b0, 32'h20, 32'h0);
    cmp("lit_pre_trap_pc", pc, 32'h20);
    instr(1'b1, 1'b0, 32'h6, 32'h0);
    cmp("lit_trap_pulse", {31'd0, misalign_trap}, 32'd1);
    cmp("lit_trap_pc", trap_pc, 32'h20);
    cmp("lit_trap_vec", pc, 32'h10);
    cmp("lit_trap_cnt", {30'd0, taken_cnt}, 32'd1);
    stall = 1'b1; step();
    cmp("lit_post_trap_req", {31'd0, imem_req}, 32'd1);
    cmp("lit_post_trap_pulse", {31'd0, misalign_trap}, 32'd0);
    imem_ack = 1'b1; step();
    cmp("lit_stall_ack_req", {31'd0, imem_req}, 32'd1);
    stall = 1'b0; step();
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_src = i[0]; imm = 32'h2; step();
    end
    cmp("lit_stall_hold_pc", pc, 32'h10);
    stall = 1'b0; pc_src = 1'b0; step();
    cmp("lit_stall_rel_pc", pc, 32'h14);

    instr(1'b1, 1'b0, 32'hFFFF_FFE8, 32'h0);
    cmp("lit_wrap_top", pc, 32'hFFFF_FFFC);
    instr(1'b0, 1'b0, 32'h0, 32'h0);
    cmp("lit_wrap_pc", pc, 32'h0);
    for (int i = 0; i < 5; i++) instr(1'b1, 1'b0, 32'h4, 32'h0);
    cmp("lit_sat_pc", pc, 32'h14);
    cmp("lit_sat_cnt", {30'd0, taken_cnt}, 32'd3);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
